inst_fetch_unit: RTL

Instruction fetch stage for the simple processor. It sits between the synchronous instruction memory and the datapath decode stage. It generates sequential fetch addresses, absorbs the memory's one-cycle read latency in a small prefetch FIFO, and hands instructions and their PCs to decode over a valid/ready handshake. It also flushes and re-targets on a redirect (branch/jump) from downstream.

---
 rtl/inst_fetch_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: sequential fetch from a one-cycle-latency memory,
// prefetch FIFO toward decode over valid/ready, flush and re-target on redirect.
module inst_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     instMem_rd,
  output logic [ADDR_W-1:0]        instMem_addr,
  input  logic [DATA_W-1:0]        instMem_data,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [DATA_W-1:0]        inst_data,
  output logic [ADDR_W-1:0]        inst_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] fifoData [DEPTH];
  logic [ADDR_W-1:0] fifoPc   [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] inflightPc;
  logic              inflight;
  logic              squash;

  logic              fetchReq;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    credits;

  // Credit check counts the outstanding read so a returning word always has a slot.
  always_comb begin
    credits  = (CNT_W+1)'(count) + (CNT_W+1)'(inflight);
    fetchReq = !reset && !redirect && (credits < (CNT_W+1)'(DEPTH));
    push     = inflight && !squash && !redirect;
    pop      = (count != '0) && inst_ready && !redirect;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc    <= RESET_PC;
      inflightPc <= '0;
      inflight   <= 1'b0;
      squash     <= 1'b0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifoData[i] <= '0;
        fifoPc[i]   <= '0;
      end
    end else begin
      squash   <= redirect && inflight;
      inflight <= fetchReq;
      if (fetchReq) begin
        inflightPc <= fetchPc;
        fetchPc    <= fetchPc + PC_STEP;
      end
      if (redirect) begin
        fetchPc <= redirect_pc;
        rdPtr   <= '0;
        wrPtr   <= '0;
        count   <= '0;
      end else begin
        if (push) begin
          fifoData[wrPtr] <= instMem_data;
          fifoPc[wrPtr]   <= inflightPc;
          wrPtr           <= wrPtr + PTR_W'(1);
        end
        if (pop) begin
          rdPtr <= rdPtr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign instMem_rd   = fetchReq;
  assign instMem_addr = fetchPc;
  assign inst_valid   = (count != '0);
  assign inst_data    = fifoData[rdPtr];
  assign inst_pc      = fifoPc[rdPtr];
  assign occupancy    = count;

endmodule
